ls_port_arbiter: RTL and testbench
==================================

# ls_port_arbiter

Sequencer and arbiter that shares the single data-SRAM port between the instruction-fetch requester and the load/store requester from MEM1. The arbiter owns the port's transaction state and routes each response back to its issuer. Load responses reach MEM2 as `dm_rdata`. The port carries one outstanding transaction at a time. Data has priority over fetch, and fetch is protected from starvation by a counter.

## Interface
- `STARVE_MAX`, default 4: number of consecutive data grants while fetch is waiting, after which fetch wins the next contested arbitration (1..15).
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req_i` in 1: fetch request; held with `i_addr_i` stable until `i_gnt_o`.
- `i_addr_i` in 32: fetch address, word aligned.
- `i_gnt_o` out 1: fetch request accepted this cycle.
- `i_rvalid_o` out 1: fetch response valid.
- `i_rdata_o` out 32: fetch data.
- `d_req_i` in 1: load/store request; held with all `d_*` stable until `d_gnt_o`.
- `d_we_i` in 1: 1 = store, 0 = load.
- `d_be_n_i` in 4: store byte enables, active low.
- `d_addr_i` in 32: data address.
- `d_wdata_i` in 32: store data.
- `d_gnt_o` out 1: data request accepted.
- `d_rvalid_o` out 1: load data valid, or store acknowledge.
- `d_rdata_o` out 32: load word, raw; MEM2 does byte/half extraction.
- `flush_i` in 1: pipeline redirect; discard the in-flight fetch response.
- `mem_req_o` out 1: SRAM port request.
- `mem_we_o` out 1: write enable.
- `mem_be_n_o` out 4: byte enables, active low.
- `mem_addr_o` out 32: port address.
- `mem_wdata_o` out 32: write data.
- `mem_gnt_i` in 1: port accepted the request.
- `mem_rvalid_i` in 1: response valid; also returned for writes.
- `mem_rdata_i` in 32: response data.

## Operation
- FSM states are IDLE, REQ and BUSY. A 1-bit `sel` (0 = fetch, 1 = data), a starve counter `scnt` of width clog2(STARVE_MAX+1), and a `drop` flag complete the state.
- In IDLE, selection works as follows:
  - only one request active: that requester wins;
  - both active: data wins, unless `scnt == STARVE_MAX`, in which case fetch wins;
  - no request: stay in IDLE.
- `mem_req_o` is driven combinationally from the winner in IDLE, and from the locked `sel` in REQ.
  - Fetch drives `we=0`, `be_n=4'hF`, `wdata=0`.
  - Data drives its own fields.
- When `mem_gnt_i` arrives with `mem_req_o` high:
  - the matching `*_gnt_o` pulses combinationally in the same cycle;
  - the next state is BUSY, with `sel` latched.
- When `mem_req_o` is high without `mem_gnt_i`:
  - the next state is REQ, with `sel` latched;
  - the selection is frozen until grant, so a late higher-priority request cannot retract or alter the issued request.
- In BUSY, `mem_req_o` is 0. On `mem_rvalid_i`:
  - `sel=0`: `i_rvalid_o` = `!drop` and `i_rdata_o` = `mem_rdata_i`;
  - `sel=1`: `d_rvalid_o` = 1 and `d_rdata_o` = `mem_rdata_i`;
  - both cases: next state IDLE, `drop` cleared.
- `scnt` update, in order:
  - data grant while `i_req_i`=1: +1, saturating at STARVE_MAX;
  - fetch grant: 0;
  - `i_req_i`=0 in any cycle: 0.
- `flush_i` handling:
  - asserted in REQ or BUSY with `sel=0`: sets `drop`, so the eventual fetch response is swallowed and the granted fetch still completes on the port;
  - asserted in the same cycle as a fetch `mem_rvalid_i`: suppresses that `i_rvalid_o`;
  - asserted in IDLE, or with `sel=1`: no effect.
- `mem_rvalid_i` in IDLE or REQ is ignored.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE, `sel` 0, `scnt` 0, `drop` 0.
- Reset mid-transaction abandons it with no response. The SRAM port shares `rst`.
- Request-to-grant is combinational, so a zero-wait grant completes in the request cycle.
- Response-to-`*_rvalid_o` is combinational, same cycle.
- Minimum issue period is 2 cycles for a 1-cycle SRAM. The next request can issue in the cycle after `mem_rvalid_i`, because IDLE follows the response.
- `i_rvalid_o` and `d_rvalid_o` are never high together; each is a 1-cycle pulse.

## Test plan
- **Lone load, zero-wait grant:**
  - stimulus: `d_req` with addr 0x100 at cycle 0; `mem_gnt` in the same cycle; `mem_rvalid` at cycle 1 with rdata 0xDEADBEEF;
  - response: `d_gnt` at cycle 0; `d_rvalid` at cycle 1 carrying 0xDEADBEEF; `mem_req` at cycle 1 = 0.
- **Contention and starvation, STARVE_MAX=4:**
  - stimulus: `i_req` and `d_req` held continuously;
  - response: 4 data grants in a row, then 1 fetch grant, then `scnt` returns to 0 and data wins again.
- **Grant stall lock:**
  - stimulus: fetch issued with `mem_gnt`=0 for 3 cycles, and `d_req` rises during the stall;
  - response: `mem_addr` stays at the fetch address; the fetch is granted first; data issues after the fetch `rvalid`.
- **Flush:**
  - stimulus: fetch in BUSY, then `flush_i` one cycle before `mem_rvalid`;
  - response: no `i_rvalid_o`; the FSM returns to IDLE; the next fetch response is delivered normally.
- **Store acknowledge:**
  - stimulus: store with `be_n`=4'b1100 and wdata 0x1234;
  - response: port fields match the request exactly; `d_rvalid` pulses once.
- **Reset mid-BUSY:**
  - stimulus: assert `rst` while in BUSY;
  - response: next cycle all outputs are 0 and state is IDLE; a stray `mem_rvalid` is ignored.

Source files
------------

// File: rtl/ls_port_arbiter.sv
// -----------------------------------------------------------------------------
// ls_port_arbiter
//
// Shares the single data-SRAM port between the instruction-fetch requester and
// the MEM1 load/store requester. One transaction is outstanding at a time.
// Data has priority over fetch; a starve counter lets a waiting fetch win once
// STARVE_MAX consecutive data grants have gone by while fetch was requesting.
//
// Ports
//   clk, rst              : single clock, synchronous active-high reset
//   i_req_i / i_addr_i    : fetch request, held stable until i_gnt_o
//   i_gnt_o               : fetch request accepted by the port this cycle
//   i_rvalid_o/i_rdata_o  : fetch response (suppressed after a flush)
//   d_req_i, d_we_i,
//   d_be_n_i, d_addr_i,
//   d_wdata_i             : load/store request, held stable until d_gnt_o
//   d_gnt_o               : data request accepted by the port this cycle
//   d_rvalid_o/d_rdata_o  : load data or store acknowledge (raw word to MEM2)
//   flush_i               : pipeline redirect, discards the in-flight fetch
//   mem_*                 : SRAM port (req/gnt handshake, rvalid response)
// -----------------------------------------------------------------------------
module ls_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,

  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_n_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,

  input  logic        flush_i,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_n_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int            SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;      // 0 = fetch owns the port, 1 = data
  logic [SW-1:0] scnt_q, scnt_d;
  logic          drop_q, drop_d;

  logic win_sel;   // arbitration result, only meaningful in IDLE
  logic cur_sel;   // requester currently driving the port
  logic issue;     // port request asserted this cycle
  logic fire;      // port request accepted this cycle
  logic resp;      // response for the outstanding transaction

  // Data wins contention unless fetch has been passed over STARVE_MAX times.
  always_comb begin
    if (i_req_i && d_req_i) win_sel = (scnt_q != SMAX);
    else                    win_sel = d_req_i;
  end

  // Once issued without a grant, the selection stays locked in REQ so a late
  // data request cannot replace a fetch already presented on the port.
  assign issue   = ((state_q == IDLE) && (i_req_i || d_req_i)) || (state_q == REQ);
  assign cur_sel = (state_q == REQ) ? sel_q : win_sel;
  assign fire    = issue && mem_gnt_i;
  assign resp    = (state_q == BUSY) && mem_rvalid_i;

  // Port mux and requester handshakes.
  // NOTE: every output of a combinational block gets a default first so that
  // no path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_n_o  = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    i_gnt_o     = 1'b0;
    d_gnt_o     = 1'b0;
    if (issue) begin
      mem_req_o = 1'b1;
      if (cur_sel) begin
        mem_we_o    = d_we_i;
        mem_be_n_o  = d_be_n_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
      end else begin
        mem_be_n_o  = 4'hF;
        mem_addr_o  = i_addr_i;
      end
      i_gnt_o = mem_gnt_i && !cur_sel;
      d_gnt_o = mem_gnt_i &&  cur_sel;
    end
  end

  // Response routing back to the issuer of the outstanding transaction.
  always_comb begin
    i_rvalid_o = 1'b0;
    i_rdata_o  = 32'h0;
    d_rvalid_o = 1'b0;
    d_rdata_o  = 32'h0;
    if (resp) begin
      if (sel_q) begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = mem_rdata_i;
      end else begin
        // A flush in the response cycle swallows it just like an earlier one.
        i_rvalid_o = !drop_q && !flush_i;
        i_rdata_o  = mem_rdata_i;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    scnt_d  = scnt_q;
    drop_d  = drop_q;

    case (state_q)
      IDLE: begin
        if (issue) begin
          sel_d   = win_sel;
          state_d = mem_gnt_i ? BUSY : REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) state_d = BUSY;
        if (flush_i && !sel_q) drop_d = 1'b1;
      end
      BUSY: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (flush_i && !sel_q) begin
          // The granted fetch still completes on the port; only its
          // response is discarded.
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Starve counter: only counts data grants that overtook a waiting fetch.
    if (!i_req_i) begin
      scnt_d = '0;
    end else if (fire && !cur_sel) begin
      scnt_d = '0;
    end else if (fire && cur_sel) begin
      scnt_d = (scnt_q == SMAX) ? SMAX : scnt_q + SW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      scnt_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      scnt_q  <= scnt_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_ls_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ls_port_arbiter
//
// Self-checking bench for ls_port_arbiter. A transaction-level model (open
// transaction record, discard flag, count of data wins over a waiting fetch)
// predicts every output each cycle; directed scenarios add literal checks,
// followed by a randomized phase with protocol-respecting requesters.
// -----------------------------------------------------------------------------
module tb_ls_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_n_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        flush_i;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_n_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  ls_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_n_i(d_be_n_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_n_o(mem_be_n_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model.
  typedef enum int {M_IDLE, M_WAIT, M_BUSY} mphase_t;
  mphase_t     m_phase = M_IDLE, n_phase = M_IDLE;
  bit          m_dat = 0, n_dat = 0;          // open transaction belongs to data
  logic        m_we = 0, n_we = 0;
  logic [3:0]  m_be = 0, n_be = 0;
  logic [31:0] m_addr = 0, n_addr = 0, m_wdata = 0, n_wdata = 0;
  bit          m_discard = 0, n_discard = 0;
  int          m_wins = 0, n_wins = 0;        // data wins while fetch waited
  bit          model_on = 0;
  bit          e_igt = 0, e_dgt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_req_i = 0; i_addr_i = 0;
    d_req_i = 0; d_we_i = 0; d_be_n_i = 4'hF; d_addr_i = 0; d_wdata_i = 0;
    flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven:
  // waits for outputs to settle, compares against the model, and prepares
  // the model's state for the coming edge.
  task automatic settle();
    bit          e_req, own, e_irv, e_drv;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    #3;
    own = m_dat; e_we = m_we; e_be = m_be; e_addr = m_addr; e_wd = m_wdata;
    e_req = 0;
    if (m_phase == M_IDLE && (i_req_i || d_req_i)) begin
      e_req = 1;
      own   = d_req_i && !(i_req_i && m_wins == STARVE_MAX);
      if (own) begin
        e_we = d_we_i; e_be = d_be_n_i; e_addr = d_addr_i; e_wd = d_wdata_i;
      end else begin
        e_we = 0; e_be = 4'hF; e_addr = i_addr_i; e_wd = 0;
      end
    end else if (m_phase == M_WAIT) begin
      e_req = 1;
    end
    e_igt = e_req && mem_gnt_i && !own;
    e_dgt = e_req && mem_gnt_i && own;
    e_irv = (m_phase == M_BUSY) && mem_rvalid_i && !own && !m_discard && !flush_i;
    e_drv = (m_phase == M_BUSY) && mem_rvalid_i && own;

    if (model_on) begin
      check("mem_req",  32'(mem_req_o),  32'(e_req));
      check("i_gnt",    32'(i_gnt_o),    32'(e_igt));
      check("d_gnt",    32'(d_gnt_o),    32'(e_dgt));
      check("i_rvalid", 32'(i_rvalid_o), 32'(e_irv));
      check("d_rvalid", 32'(d_rvalid_o), 32'(e_drv));
      if (e_req) begin
        check("mem_we",    32'(mem_we_o),   32'(e_we));
        check("mem_be_n",  32'(mem_be_n_o), 32'(e_be));
        check("mem_addr",  mem_addr_o,      e_addr);
        check("mem_wdata", mem_wdata_o,     e_wd);
      end
      if (e_irv) check("i_rdata", i_rdata_o, mem_rdata_i);
      if (e_drv) check("d_rdata", d_rdata_o, mem_rdata_i);
    end

    n_phase = m_phase; n_dat = m_dat; n_we = m_we; n_be = m_be;
    n_addr = m_addr; n_wdata = m_wdata; n_discard = m_discard; n_wins = m_wins;
    if (rst) begin
      n_phase = M_IDLE; n_dat = 0; n_discard = 0; n_wins = 0;
    end else begin
      if (!i_req_i || e_igt) n_wins = 0;
      else if (e_dgt)        n_wins = (m_wins < STARVE_MAX) ? m_wins + 1 : STARVE_MAX;
      case (m_phase)
        M_IDLE: if (e_req) begin
          n_dat = own; n_we = e_we; n_be = e_be; n_addr = e_addr; n_wdata = e_wd;
          n_phase = mem_gnt_i ? M_BUSY : M_WAIT;
        end
        M_WAIT: begin
          if (mem_gnt_i) n_phase = M_BUSY;
          if (flush_i && !m_dat) n_discard = 1;
        end
        default: begin
          if (mem_rvalid_i) begin
            n_phase = M_IDLE; n_discard = 0;
          end else if (flush_i && !m_dat) begin
            n_discard = 1;
          end
        end
      endcase
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_phase = n_phase; m_dat = n_dat; m_we = n_we; m_be = n_be;
    m_addr = n_addr; m_wdata = n_wdata; m_discard = n_discard; m_wins = n_wins;
    if (rst) model_on = 1;
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  bit exp_d_win [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;

    // ---- Reset state ------------------------------------------------------
    cycle();
    rst = 0;
    settle();
    check("reset_outputs",
          32'({mem_req_o, mem_we_o, mem_be_n_o, i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o}), 32'h0);
    check("reset_addr_rdata", mem_addr_o | mem_wdata_o | i_rdata_o | d_rdata_o, 32'h0);
    advance();

    // ---- Lone load, zero-wait grant ---------------------------------------
    d_req_i = 1; d_addr_i = 32'h100; mem_gnt_i = 1;
    settle();
    check("load_d_gnt",    32'(d_gnt_o), 32'h1);
    check("load_mem_addr", mem_addr_o,   32'h100);
    advance();
    d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    settle();
    check("load_d_rvalid", 32'(d_rvalid_o), 32'h1);
    check("load_d_rdata",  d_rdata_o,       32'hDEAD_BEEF);
    check("load_busy_req", 32'(mem_req_o),  32'h0);
    advance();
    idle_inputs();

    // ---- Store acknowledge ------------------------------------------------
    d_req_i = 1; d_we_i = 1; d_be_n_i = 4'b1100; d_addr_i = 32'h200;
    d_wdata_i = 32'h1234; mem_gnt_i = 1;
    settle();
    check("store_we",    32'(mem_we_o),   32'h1);
    check("store_be_n",  32'(mem_be_n_o), 32'hC);
    check("store_addr",  mem_addr_o,      32'h200);
    check("store_wdata", mem_wdata_o,     32'h1234);
    advance();
    idle_inputs();
    mem_rvalid_i = 1;
    settle();
    check("store_ack", 32'(d_rvalid_o), 32'h1);
    advance();
    mem_rvalid_i = 0;
    settle();
    check("store_ack_pulse", 32'(d_rvalid_o), 32'h0);
    advance();

    // ---- Contention and starvation ----------------------------------------
    i_req_i = 1; i_addr_i = 32'h40;
    d_req_i = 1; d_addr_i = 32'h300;
    for (int t = 0; t < 6; t++) begin
      mem_gnt_i = 1; mem_rvalid_i = 0;
      settle();
      check($sformatf("starve_d_gnt_%0d", t), 32'(d_gnt_o), 32'(exp_d_win[t]));
      check($sformatf("starve_i_gnt_%0d", t), 32'(i_gnt_o), 32'(!exp_d_win[t]));
      advance();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'(t);
      cycle();
    end
    idle_inputs();
    cycle();

    // ---- Grant stall lock -------------------------------------------------
    i_req_i = 1; i_addr_i = 32'h80;
    settle();
    check("stall_addr_0", mem_addr_o, 32'h80);
    advance();
    d_req_i = 1; d_addr_i = 32'h400;
    for (int s = 1; s < 3; s++) begin
      settle();
      check($sformatf("stall_addr_%0d", s), mem_addr_o, 32'h80);
      check($sformatf("stall_d_gnt_%0d", s), 32'(d_gnt_o), 32'h0);
      advance();
    end
    mem_gnt_i = 1;
    settle();
    check("stall_i_gnt", 32'(i_gnt_o), 32'h1);
    check("stall_d_gnt", 32'(d_gnt_o), 32'h0);
    advance();
    i_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0001;
    settle();
    check("stall_i_rvalid", 32'(i_rvalid_o), 32'h1);
    check("stall_i_rdata",  i_rdata_o,       32'hCAFE_0001);
    advance();
    mem_rvalid_i = 0; mem_gnt_i = 1;
    settle();
    check("stall_then_d_gnt", 32'(d_gnt_o), 32'h1);
    check("stall_then_addr",  mem_addr_o,   32'h400);
    advance();
    d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    cycle();
    idle_inputs();

    // ---- Flush ------------------------------------------------------------
    i_req_i = 1; i_addr_i = 32'h44; mem_gnt_i = 1;
    settle();
    check("flush_i_gnt", 32'(i_gnt_o), 32'h1);
    advance();
    i_req_i = 0; mem_gnt_i = 0;
    cycle();
    flush_i = 1;
    cycle();
    flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h5555;
    settle();
    check("flush_no_rvalid", 32'(i_rvalid_o), 32'h0);
    advance();
    mem_rvalid_i = 0;
    settle();
    check("flush_idle_req", 32'(mem_req_o), 32'h0);
    advance();
    i_req_i = 1; i_addr_i = 32'h48; mem_gnt_i = 1;
    cycle();
    i_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h7777;
    settle();
    check("flush_next_rvalid", 32'(i_rvalid_o), 32'h1);
    check("flush_next_rdata",  i_rdata_o,       32'h7777);
    advance();
    idle_inputs();

    // ---- Reset mid-BUSY ---------------------------------------------------
    d_req_i = 1; d_addr_i = 32'h500; mem_gnt_i = 1;
    cycle();
    d_req_i = 0; mem_gnt_i = 0; rst = 1;
    cycle();
    rst = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
    settle();
    check("rst_busy_d_rvalid", 32'(d_rvalid_o), 32'h0);
    check("rst_busy_outputs",
          32'({mem_req_o, i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o}), 32'h0);
    advance();
    idle_inputs();

    // ---- Randomized traffic -----------------------------------------------
    for (int c = 0; c < 4000; c++) begin
      if (!i_req_i || e_igt) begin
        i_req_i  = 1'($urandom_range(0, 1));
        i_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_req_i || e_dgt) begin
        d_req_i   = 1'($urandom_range(0, 1));
        d_we_i    = 1'($urandom_range(0, 1));
        d_be_n_i  = 4'($urandom_range(0, 15));
        d_addr_i  = $urandom();
        d_wdata_i = $urandom();
      end
      mem_gnt_i    = 1'($urandom_range(0, 1));
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = $urandom();
      flush_i      = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 99) == 0);
      settle();
      check("rvalid_exclusive", 32'(i_rvalid_o & d_rvalid_o), 32'h0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
